// File: rtl/dsp_uv_pkg.sv
// Shared widths, accumulator op encodings and constants for the U/V accumulate stage.
package dsp_uv_pkg;

    localparam int unsigned UvW = 45;
    localparam int unsigned PW  = 48;

    typedef enum logic [1:0] {
        OpLoad  = 2'b00,
        OpAdd   = 2'b01,
        OpSub   = 2'b10,
        OpClear = 2'b11
    } opmode_e;

    localparam logic [PW-1:0]  PMax   = 48'h7FFF_FFFF_FFFF;
    localparam logic [PW-1:0]  PMin   = 48'h8000_0000_0000;
    // Idle partial-product pair value; two of these sum to zero mod 2^45.
    localparam logic [UvW-1:0] UvIdle = 45'h1000_0000_0000;

endpackage

// File: rtl/dsp_uv_sum.sv
// Stage 1: folds the U/V partial products into a sign-extended product and
// pipelines the op/valid qualifiers alongside it.
module dsp_uv_sum
    import dsp_uv_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           cem_i,
    input  logic           valid_i,
    input  logic [UvW-1:0] u_i,
    input  logic [UvW-1:0] v_i,
    input  opmode_e        op_i,
    output logic [PW-1:0]  m_o,
    output logic           m_valid_o,
    output opmode_e        m_op_o
);

    logic [UvW-1:0] m45;
    logic [PW-1:0]  m_d, m_q;
    logic           m_valid_q;
    opmode_e        m_op_q;

    // Carry out of the 45-bit sum is intentionally dropped.
    always_comb begin
        m45 = u_i + v_i;
        m_d = {{(PW - UvW){m45[UvW-1]}}, m45};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            m_q       <= '0;
            m_valid_q <= 1'b0;
            m_op_q    <= OpLoad;
        end else if (cem_i) begin
            m_q       <= m_d;
            m_valid_q <= valid_i;
            m_op_q    <= op_i;
        end
    end

    assign m_o       = m_q;
    assign m_valid_o = m_valid_q;
    assign m_op_o    = m_op_q;

endmodule

// File: rtl/dsp_uv_accum.sv
// Post-multiplier accumulate stage: U+V product into a 48-bit load/add/sub/clear
// accumulator with overflow flags, optional saturation and pattern detect.
module dsp_uv_accum
    import dsp_uv_pkg::*;
#(
    parameter bit            SATURATE = 1'b0,
    parameter logic [PW-1:0] PATTERN  = '0,
    parameter logic [PW-1:0] MASK     = '0
) (
    input  logic           CLK,
    input  logic           RSTP_B,
    input  logic           CEM,
    input  logic           CEP,
    input  logic           VALID_IN,
    input  logic [UvW-1:0] U,
    input  logic [UvW-1:0] V,
    input  logic [1:0]     OPMODE,
    output logic [PW-1:0]  P,
    output logic           P_VALID,
    output logic           OVERFLOW,
    output logic           UNDERFLOW,
    output logic           OVF_STICKY,
    output logic           PATDET
);

    logic [PW-1:0] m;
    logic          m_valid;
    opmode_e       m_op;

    dsp_uv_sum u_sum (
        .clk_i     (CLK),
        .rst_ni    (RSTP_B),
        .cem_i     (CEM),
        .valid_i   (VALID_IN),
        .u_i       (U),
        .v_i       (V),
        .op_i      (opmode_e'(OPMODE)),
        .m_o       (m),
        .m_valid_o (m_valid),
        .m_op_o    (m_op)
    );

    logic [PW-1:0] p_q, p_d;
    logic          p_valid_q;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          sticky_q, sticky_d;
    logic          patdet_q, patdet_d;
    logic          fire;
    logic [PW:0]   sum49;
    logic          arith;

    always_comb begin
        fire     = CEP & m_valid;
        p_d      = p_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        sticky_d = sticky_q;
        patdet_d = patdet_q;
        sum49    = '0;
        arith    = (m_op == OpAdd) || (m_op == OpSub);

        if (fire) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            unique case (m_op)
                OpLoad:  p_d = m;
                OpAdd:   sum49 = {p_q[PW-1], p_q} + {m[PW-1], m};
                OpSub:   sum49 = {p_q[PW-1], p_q} - {m[PW-1], m};
                OpClear: p_d = '0;
            endcase

            // Overflow shows as disagreement between the guard bit and the sign bit.
            if (arith) begin
                ovf_d = (sum49[PW] ^ sum49[PW-1]) & ~sum49[PW];
                unf_d = (sum49[PW] ^ sum49[PW-1]) & sum49[PW];
                if (SATURATE && ovf_d) begin
                    p_d = PMax;
                end else if (SATURATE && unf_d) begin
                    p_d = PMin;
                end else begin
                    p_d = sum49[PW-1:0];
                end
            end

            sticky_d = (m_op == OpClear) ? 1'b0 : (sticky_q | ovf_d | unf_d);
            patdet_d = (((p_d ^ PATTERN) & ~MASK) == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTP_B) begin
            p_q       <= '0;
            p_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            sticky_q  <= 1'b0;
            patdet_q  <= 1'b0;
        end else begin
            p_q       <= p_d;
            p_valid_q <= fire;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            sticky_q  <= sticky_d;
            patdet_q  <= patdet_d;
        end
    end

    assign P          = p_q;
    assign P_VALID    = p_valid_q;
    assign OVERFLOW   = ovf_q;
    assign UNDERFLOW  = unf_q;
    assign OVF_STICKY = sticky_q;
    assign PATDET     = patdet_q;

endmodule

// File: tb/tb_dsp_uv_accum.sv
// Bench for dsp_uv_accum: wrapping and saturating instances driven in lockstep and
// compared every cycle against an integer-arithmetic reference model.
module tb_dsp_uv_accum;
    import dsp_uv_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTP_B, CEM, CEP, VALID_IN;
    logic [44:0] U, V;
    logic [1:0]  OPMODE;

    logic [47:0] p0, p1;
    logic        pv0, pv1, ov0, ov1, un0, un1, st0, st1, pd0, pd1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dsp_uv_accum #(.SATURATE(1'b0), .PATTERN(48'd12), .MASK(48'h0)) dut0 (
        .CLK(CLK), .RSTP_B(RSTP_B), .CEM(CEM), .CEP(CEP), .VALID_IN(VALID_IN),
        .U(U), .V(V), .OPMODE(OPMODE), .P(p0), .P_VALID(pv0), .OVERFLOW(ov0),
        .UNDERFLOW(un0), .OVF_STICKY(st0), .PATDET(pd0)
    );

    dsp_uv_accum #(.SATURATE(1'b1), .PATTERN(48'h5), .MASK(48'hFFFF_FFFF_FFF0)) dut1 (
        .CLK(CLK), .RSTP_B(RSTP_B), .CEM(CEM), .CEP(CEP), .VALID_IN(VALID_IN),
        .U(U), .V(V), .OPMODE(OPMODE), .P(p1), .P_VALID(pv1), .OVERFLOW(ov1),
        .UNDERFLOW(un1), .OVF_STICKY(st1), .PATDET(pd1)
    );

    // Reference model: signed integers, two accumulators (0 = wrap, 1 = saturate)
    localparam longint Lim  = 64'sd140737488355328;  // 2^47
    localparam longint PMaxL = Lim - 1;
    localparam longint PMinL = -Lim;
    localparam longint ModL  = 2 * Lim;

    longint mp;
    bit     mv;
    int     mop;
    longint ep[2];
    bit     epv[2], eov[2], eun[2], est[2], epd[2];

    function automatic longint product(input logic [44:0] u, input logic [44:0] v);
        logic [44:0] s;
        longint x;
        s = u + v;
        x = longint'(s);
        if (s[44]) x = x - (64'sd1 <<< 45);
        return x;
    endfunction

    function automatic bit match(input int k, input longint r);
        logic [47:0] b;
        b = 48'(r);
        if (k == 0) return b == 48'd12;
        return b[3:0] == 4'h5;
    endfunction

    task automatic model_edge(input bit rst, input bit cem, input bit cep, input bit vin,
                              input logic [44:0] u, input logic [44:0] v,
                              input logic [1:0] op);
        longint r;
        bit o, n;
        if (!rst) begin
            mp = 0; mv = 0; mop = 0;
            for (int k = 0; k < 2; k++) begin
                ep[k] = 0; epv[k] = 0; eov[k] = 0; eun[k] = 0; est[k] = 0; epd[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                epv[k] = cep && mv;
                if (epv[k]) begin
                    o = 0; n = 0;
                    case (mop)
                        0:       r = mp;
                        1:       r = ep[k] + mp;
                        2:       r = ep[k] - mp;
                        default: r = 0;
                    endcase
                    if (r > PMaxL) begin
                        o = 1; r = (k == 1) ? PMaxL : r - ModL;
                    end else if (r < PMinL) begin
                        n = 1; r = (k == 1) ? PMinL : r + ModL;
                    end
                    ep[k]  = r;
                    eov[k] = o;
                    eun[k] = n;
                    est[k] = (mop == 3) ? 1'b0 : (est[k] | o | n);
                    epd[k] = match(k, r);
                end
            end
            if (cem) begin
                mp = product(u, v); mv = vin; mop = int'(op);
            end
        end
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("P0",   p0,       48'(ep[0]));
        check("PV0",  48'(pv0), 48'(epv[0]));
        check("OVF0", 48'(ov0), 48'(eov[0]));
        check("UNF0", 48'(un0), 48'(eun[0]));
        check("STK0", 48'(st0), 48'(est[0]));
        check("PAT0", 48'(pd0), 48'(epd[0]));
        check("P1",   p1,       48'(ep[1]));
        check("PV1",  48'(pv1), 48'(epv[1]));
        check("OVF1", 48'(ov1), 48'(eov[1]));
        check("UNF1", 48'(un1), 48'(eun[1]));
        check("STK1", 48'(st1), 48'(est[1]));
        check("PAT1", 48'(pd1), 48'(epd[1]));
    endtask

    task automatic step(input bit rst, input bit cem, input bit cep, input bit vin,
                        input logic [44:0] u, input logic [44:0] v, input logic [1:0] op);
        RSTP_B = rst; CEM = cem; CEP = cep; VALID_IN = vin; U = u; V = v; OPMODE = op;
        @(posedge CLK);
        model_edge(rst, cem, cep, vin, u, v, op);
        #1;
        check_all();
    endtask

    task automatic go(input bit vin, input logic [44:0] u, input logic [44:0] v,
                      input logic [1:0] op);
        step(1'b1, 1'b1, 1'b1, vin, u, v, op);
    endtask

    function automatic logic [44:0] rand45();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return 45'($urandom_range(0, 20));
            1:       return w[44:0];
            2:       return 45'h0FFF_FFFF_FFFF - 45'($urandom_range(0, 1000));
            default: return 45'h1000_0000_0000 + 45'($urandom_range(0, 1000));
        endcase
    endfunction

    logic [44:0] big_pos, big_neg, minus1;

    initial begin
        big_pos = 45'h0FFF_FFFF_FFFF;
        big_neg = UvIdle;
        minus1  = 45'h1FFF_FFFF_FFFF;
        RSTP_B = 1'b0; CEM = 1'b0; CEP = 1'b0; VALID_IN = 1'b0;
        U = '0; V = '0; OPMODE = 2'b00;

        step(1'b0, 1'b1, 1'b1, 1'b1, 45'd1, 45'd1, 2'b01);
        step(1'b0, 1'b1, 1'b1, 1'b1, 45'd1, 45'd1, 2'b01);
        check("rst_p", p0, 48'd0);

        // Idle pair loads zero, first P_VALID after two edges
        go(1'b1, UvIdle, UvIdle, 2'b00);
        check("idle_no_pv_yet", 48'(pv0), 48'd0);
        go(1'b0, '0, '0, 2'b00);
        check("idle_pv", 48'(pv0), 48'd1);
        check("idle_p", p0, 48'd0);

        go(1'b1, 45'd5, 45'd7, 2'b00);
        go(1'b1, 45'd3, 45'd0, 2'b01);
        check("load12", p0, 48'd12);
        check("pat12", 48'(pd0), 48'd1);
        go(1'b1, 45'd2, 45'd0, 2'b10);
        check("add15", p0, 48'd15);
        go(1'b0, '0, '0, 2'b00);
        check("sub13", p0, 48'd13);

        go(1'b1, minus1, 45'd0, 2'b00);
        go(1'b0, '0, '0, 2'b00);
        check("neg1", p0, 48'hFFFF_FFFF_FFFF);

        // Climb to +max, then push past it
        go(1'b1, big_pos, 45'd0, 2'b00);
        for (int i = 0; i < 7; i++) go(1'b1, big_pos, 45'd0, 2'b01);
        go(1'b1, 45'd7, 45'd0, 2'b01);
        go(1'b1, 45'd1, 45'd0, 2'b01);
        check("at_max", p0, PMax);
        go(1'b1, 45'd1, 45'd0, 2'b01);
        check("wrap_p", p0, PMin);
        check("wrap_ovf", 48'(ov0), 48'd1);
        check("wrap_stk", 48'(st0), 48'd1);
        check("sat_p", p1, PMax);
        check("sat_ovf", 48'(ov1), 48'd1);
        go(1'b1, '0, '0, 2'b11);
        go(1'b0, '0, '0, 2'b00);
        check("clr_p", p0, 48'd0);
        check("clr_stk", 48'(st0), 48'd0);

        // Descend to -2^47, then one further step down
        go(1'b1, big_neg, 45'd0, 2'b00);
        for (int i = 0; i < 7; i++) go(1'b1, big_neg, 45'd0, 2'b01);
        go(1'b1, minus1, 45'd0, 2'b01);
        go(1'b0, '0, '0, 2'b00);
        check("unf_flag", 48'(un0), 48'd1);
        check("unf_sat", p1, PMin);
        go(1'b1, '0, '0, 2'b11);

        // CEP held low mid-stream
        go(1'b1, 45'd3, 45'd0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 45'd4, 45'd0, 2'b01);
            check("cep_hold_pv", 48'(pv0), 48'd0);
        end
        go(1'b0, '0, '0, 2'b00);
        go(1'b0, '0, '0, 2'b00);

        // Reset mid-stream drops the in-flight sample
        go(1'b1, 45'd10, 45'd0, 2'b01);
        step(1'b0, 1'b1, 1'b1, 1'b1, 45'd11, 45'd0, 2'b01);
        check("mid_rst_p", p0, 48'd0);
        go(1'b1, 45'd9, 45'd0, 2'b00);
        check("post_rst_pv", 48'(pv0), 48'd0);
        go(1'b0, '0, '0, 2'b00);
        check("post_rst_p", p0, 48'd9);

        // CEM low with CEP high repeats the held sample
        go(1'b1, 45'd2, 45'd0, 2'b01);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 2'b00);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 2'b00);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 2'b00);
        check("cem_refire", p0, 48'd15);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] op;
            r = $urandom_range(0, 9);
            op = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0),
                 rand45(), rand45(), op);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
